// File: rtl/byte_packer.sv
// byte_packer
// Packs a stream of bytes into 32-bit words with a per-lane keep mask.
// A word closes when its fourth byte arrives or when a byte marked
// in_last arrives. The next packet always starts again at lane 0.
//
// Parameters
//   BIG_END   0: first byte of a word in out_data[7:0], keep bit 0
//             1: first byte of a word in out_data[31:24], keep bit 3
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_data / in_last are valid this cycle
//   in_data    input byte
//   in_last    final byte of a packet
//   in_ready   packer accepts a byte this cycle
//   out_valid  out_data / out_keep / out_last are valid
//   out_data   packed word
//   out_keep   per-lane valid mask, aligned with out_data lanes
//   out_last   word carries the final byte of a packet
//   out_ready  downstream accepts the word this cycle
//   word_cnt   words accepted downstream, saturating at 16'hFFFF

module byte_packer #(
    parameter bit BIG_END = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] word_cnt
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] acc_q, acc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [3:0]  out_keep_q, out_keep_d;
    logic        out_last_q, out_last_d;
    logic [15:0] word_cnt_q, word_cnt_d;

    logic        in_fire;
    logic        out_fire;
    logic        word_done;
    logic [31:0] word_lanes;
    logic [3:0]  keep_lanes;
    logic [31:0] packed_data;
    logic [3:0]  packed_keep;

    // Handshake. in_ready looks straight at out_ready so a word that is
    // draining this cycle frees the output register for the next one.
    always_comb begin
        in_ready  = !(out_valid_q && !out_ready);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid_q && out_ready;
        word_done = in_fire && (in_last || (idx_q == 2'd3));
    end

    // Word in logical lane order (lane k in bits 8k+7:8k). Lanes above idx
    // are always zero because the accumulator is cleared whenever a word
    // closes, so no extra masking is needed.
    always_comb begin
        word_lanes = {8'h00, acc_q};
        word_lanes[{idx_q, 3'b000} +: 8] = in_data;
        case (idx_q)
            2'd0:    keep_lanes = 4'b0001;
            2'd1:    keep_lanes = 4'b0011;
            2'd2:    keep_lanes = 4'b0111;
            default: keep_lanes = 4'b1111;
        endcase
    end

    // Physical lane placement: big-endian mirrors both bytes and keep bits.
    always_comb begin
        packed_data = '0;
        packed_keep = '0;
        for (int k = 0; k < 4; k++) begin
            if (BIG_END) begin
                packed_data[31-8*k -: 8] = word_lanes[8*k +: 8];
                packed_keep[3-k]         = keep_lanes[k];
            end else begin
                packed_data[8*k +: 8]    = word_lanes[8*k +: 8];
                packed_keep[k]           = keep_lanes[k];
            end
        end
    end

    // Next state for the byte index, accumulator, output register and
    // word counter.
    always_comb begin
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        word_cnt_d  = word_cnt_q;

        if (word_done) begin
            idx_d       = 2'd0;
            acc_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = packed_data;
            out_keep_d  = packed_keep;
            out_last_d  = in_last;
        end else begin
            if (in_fire) begin
                idx_d = idx_q + 2'd1;
                acc_d = word_lanes[23:0];
            end
            if (out_fire) begin
                out_valid_d = 1'b0;
            end
        end

        if (out_fire && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer
// Drives one little-endian and one big-endian byte_packer with the same
// stimulus. A queue-based reference model predicts every output word.

module tb_byte_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_le, in_ready_be;
    logic        out_valid_le, out_valid_be;
    logic [31:0] out_data_le, out_data_be;
    logic [3:0]  out_keep_le, out_keep_be;
    logic        out_last_le, out_last_be;
    logic [15:0] word_cnt_le, word_cnt_be;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Reference model state
    logic [7:0]  pend[$];
    logic        m_valid;
    logic [31:0] m_data_le, m_data_be;
    logic [3:0]  m_keep_le, m_keep_be;
    logic        m_last;
    logic [15:0] m_cnt;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        r;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[8];

    byte_packer #(.BIG_END(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready_le),
        .out_valid(out_valid_le), .out_data(out_data_le),
        .out_keep(out_keep_le), .out_last(out_last_le),
        .out_ready(out_ready), .word_cnt(word_cnt_le)
    );

    byte_packer #(.BIG_END(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready_be),
        .out_valid(out_valid_be), .out_data(out_data_be),
        .out_keep(out_keep_be), .out_last(out_last_be),
        .out_ready(out_ready), .word_cnt(word_cnt_be)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison with counting and a FAIL line on mismatch
    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic modelStep(input logic v, input logic [7:0] d, input logic l,
                             input logic ordy, input logic rstn, input logic rdy);
        if (!rstn) begin
            pend.delete();
            m_valid   = 1'b0;
            m_data_le = '0;
            m_data_be = '0;
            m_keep_le = '0;
            m_keep_be = '0;
            m_last    = 1'b0;
            m_cnt     = '0;
            return;
        end
        if (m_valid && ordy) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_valid = 1'b0;
        end
        if (v && rdy) begin
            pend.push_back(d);
            if (l || pend.size() == 4) begin
                m_data_le = '0;
                m_data_be = '0;
                m_keep_le = '0;
                m_keep_be = '0;
                for (int i = 0; i < pend.size(); i++) begin
                    m_data_le[8*i +: 8]    = pend[i];
                    m_data_be[31-8*i -: 8] = pend[i];
                    m_keep_le[i]           = 1'b1;
                    m_keep_be[3-i]         = 1'b1;
                end
                m_last  = l;
                m_valid = 1'b1;
                pend.delete();
            end
        end
    endtask

    // Drive one cycle of inputs (at the falling edge), check in_ready,
    // let the rising edge happen and update the model
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                                 input logic ordy, input logic rstn);
        logic rdy;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        rst_n     = rstn;
        #1;
        rdy = !(m_valid && !ordy);
        if (rstn) begin
            checkValue("in_ready_le", {31'b0, in_ready_le}, {31'b0, rdy});
            checkValue("in_ready_be", {31'b0, in_ready_be}, {31'b0, rdy});
        end
        @(posedge clk);
        modelStep(v, d, l, ordy, rstn, rdy);
        @(negedge clk);
    endtask

    // Compare both instances against the model
    task automatic checkOutput();
        checkValue("out_valid_le", {31'b0, out_valid_le}, {31'b0, m_valid});
        checkValue("out_valid_be", {31'b0, out_valid_be}, {31'b0, m_valid});
        checkValue("word_cnt_le", {16'b0, word_cnt_le}, {16'b0, m_cnt});
        checkValue("word_cnt_be", {16'b0, word_cnt_be}, {16'b0, m_cnt});
        if (m_valid) begin
            checkValue("out_data_le", out_data_le, m_data_le);
            checkValue("out_data_be", out_data_be, m_data_be);
            checkValue("out_keep_le", {28'b0, out_keep_le}, {28'b0, m_keep_le});
            checkValue("out_keep_be", {28'b0, out_keep_be}, {28'b0, m_keep_be});
            checkValue("out_last_le", {31'b0, out_last_le}, {31'b0, m_last});
            checkValue("out_last_be", {31'b0, out_last_be}, {31'b0, m_last});
        end
    endtask

    initial begin
        int guard;

        // Hand-computed little-endian vectors: full word, short last word,
        // and a following packet that must restart at lane 0
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 16'd0};
        tbl[4] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd1};
        tbl[5] = '{1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 32'h0000BBAA, 4'h3, 1'b1, 16'd1};
        tbl[6] = '{1'b1, 8'hCC, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd2};
        tbl[7] = '{1'b1, 8'hDD, 1'b1, 1'b1, 1'b1, 32'h0000DDCC, 4'h3, 1'b1, 16'd2};

        m_valid = 1'b0;
        m_cnt   = '0;

        // Reset state
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkValue("reset_out_valid", {31'b0, out_valid_le}, 32'd0);
        checkValue("reset_out_data", out_data_le, 32'h0);
        checkValue("reset_out_keep", {28'b0, out_keep_le}, 32'd0);
        checkValue("reset_out_last", {31'b0, out_last_le}, 32'd0);
        checkValue("reset_word_cnt", {16'b0, word_cnt_le}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checkValue("reset_in_ready", {31'b0, in_ready_le}, 32'd1);
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r, 1'b1);
            checkOutput();
            checkValue($sformatf("tbl%0d_valid", i), {31'b0, out_valid_le}, {31'b0, tbl[i].ev});
            checkValue($sformatf("tbl%0d_cnt", i), {16'b0, word_cnt_le}, {16'b0, tbl[i].ec});
            if (tbl[i].ev) begin
                checkValue($sformatf("tbl%0d_data", i), out_data_le, tbl[i].ed);
                checkValue($sformatf("tbl%0d_keep", i), {28'b0, out_keep_le}, {28'b0, tbl[i].ek});
                checkValue($sformatf("tbl%0d_last", i), {31'b0, out_last_le}, {31'b0, tbl[i].el});
            end
        end

        // Fill a word, then stall downstream for 10 cycles
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, (i == 1), 1'b1);
            checkOutput();
        end
        checkValue("be_word_data", out_data_be, 32'h01020304);
        checkValue("be_word_keep", {28'b0, out_keep_be}, 32'hF);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
            checkOutput();
            checkValue("stall_in_ready", {31'b0, in_ready_le}, 32'd0);
            checkValue("stall_data", out_data_le, 32'h04030201);
            checkValue("stall_valid", {31'b0, out_valid_le}, 32'd1);
        end

        // Release and stream an 8-byte burst: no bubbles allowed
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            checkValue("burst_in_ready", {31'b0, in_ready_le}, 32'd1);
            applyStimulus(1'b1, 8'h80 + 8'(i), 1'b0, 1'b1, 1'b1);
            checkOutput();
        end
        checkValue("burst_word2", out_data_le, 32'h87868584);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput();

        // Single-byte packet
        applyStimulus(1'b1, 8'h7E, 1'b1, 1'b1, 1'b1);
        checkOutput();
        checkValue("single_be_data", out_data_be, 32'h7E000000);
        checkValue("single_be_keep", {28'b0, out_keep_be}, 32'h8);
        checkValue("single_le_data", out_data_le, 32'h0000007E);
        checkValue("single_le_keep", {28'b0, out_keep_le}, 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput();

        // Reset mid-word discards partial data
        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'hE2, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput();
        checkValue("rst_mid_cnt", {16'b0, word_cnt_le}, 32'd0);
        checkValue("rst_mid_valid", {31'b0, out_valid_le}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1);
            checkOutput();
        end
        checkValue("post_rst_data", out_data_le, 32'hA4A3A2A1);
        checkValue("post_rst_keep", {28'b0, out_keep_le}, 32'hF);

        // Reset while a word is stalled: no transfer on the reset cycle
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput();
        checkValue("rst_stall_cnt", {16'b0, word_cnt_le}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7), 1'b1);
            checkOutput();
        end

        // Counter saturation: stream 1-byte words until the count tops out
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            applyStimulus(1'b1, 8'(guard), 1'b1, 1'b1, 1'b1);
            guard++;
        end
        if (guard >= 70000) begin
            miss_cnt++;
            vec_cnt++;
            $display("[TB] FAIL sat_timeout: got %0d cycles, expected fewer than 70000", guard);
        end
        checkOutput();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1);
            checkOutput();
            checkValue("sat_cnt_le", {16'b0, word_cnt_le}, 32'h0000FFFF);
            checkValue("sat_cnt_be", {16'b0, word_cnt_be}, 32'h0000FFFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
